// File: rtl/mod_exp_ctrl.sv
// -----------------------------------------------------------------------------
// mod_exp_ctrl
//   Square-and-multiply modular exponentiation sequencer:
//     result = base^exponent mod p
//   This block has no multiplier of its own. It acts as the initiator of the
//   ModMul enable/done handshake and drives an external ModMul instance that is
//   built for the same modulus p and the same WIDTH.
//
// Parameters
//   WIDTH      operand/result width (must match the ModMul width)
//   EXP_WIDTH  exponent width
//   TIMEOUT    max cycles mm_enable may stay high waiting for mm_done
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (shared with ModMul)
//   start      in   one-cycle request, sampled only in IDLE
//   base       in   WIDTH      base (caller guarantees base < p)
//   exponent   in   EXP_WIDTH  unsigned exponent
//   busy       out  high from the cycle after start is accepted until done
//   done       out  one-cycle pulse, result/err valid
//   result     out  WIDTH      registered result
//   err        out  timeout abort flag, valid with done
//   mm_a/mm_b  out  WIDTH      ModMul operands
//   mm_enable  out  ModMul enable
//   mm_r       in   WIDTH      ModMul result
//   mm_done    in   ModMul completion (ignored while mm_enable is low)
// -----------------------------------------------------------------------------
module mod_exp_ctrl #(
  parameter int WIDTH     = 128,
  parameter int EXP_WIDTH = 128,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic                 mm_enable,
  input  logic [WIDTH-1:0]     mm_r,
  input  logic                 mm_done
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_MUL,
    S_GAP,
    S_FIN
  } state_t;

  state_t                 r_state;
  state_t                 r_next_op;   // operation to issue after the GAP cycle
  logic [WIDTH-1:0]       r_acc;
  logic [WIDTH-1:0]       r_base;
  logic [EXP_WIDTH-1:0]   r_exp;
  logic [IDX_W-1:0]       r_idx;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_abort;

  logic                   r_busy;
  logic                   r_done;
  logic [WIDTH-1:0]       r_result;
  logic                   r_err;
  logic [WIDTH-1:0]       r_mm_a;
  logic [WIDTH-1:0]       r_mm_b;
  logic                   r_mm_enable;

  logic [IDX_W-1:0]       w_msb;
  logic                   w_exp_zero;
  logic                   w_cur_bit;

  // Priority encoder: index of the most significant set bit of exponent.
  // Later (higher) iterations overwrite earlier ones, so the top set bit wins.
  // NOTE: w_msb gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_msb = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (exponent[i]) w_msb = IDX_W'(i);
    end
  end

  assign w_exp_zero = (exponent == '0);
  assign w_cur_bit  = r_exp[r_idx];

  // NOTE: all state lives in this one clocked block and uses non-blocking
  // assignments, so every read sees the value from before this edge.
  // NOTE: the datapath registers are reset alongside the control state; the
  // outputs must read zero straight out of reset and the cost is a few flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_next_op   <= S_SQR;
      r_acc       <= '0;
      r_base      <= '0;
      r_exp       <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_mm_a      <= '0;
      r_mm_b      <= '0;
      r_mm_enable <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
            r_base  <= base;
            r_exp   <= exponent;
            if (w_exp_zero) begin
              r_acc   <= WIDTH'(1);
              r_state <= S_FIN;
            end else if (w_msb == '0) begin
              // exponent == 1: the leading one needs no multiply
              r_acc   <= base;
              r_state <= S_FIN;
            end else begin
              // The leading one is absorbed by acc = base; first op is a square.
              r_acc       <= base;
              r_idx       <= w_msb - 1'b1;
              r_mm_a      <= base;
              r_mm_b      <= base;
              r_mm_enable <= 1'b1;
              r_tmo       <= '0;
              r_state     <= S_SQR;
            end
          end
        end

        S_SQR, S_MUL: begin
          if (mm_done) begin
            r_acc       <= mm_r;
            r_mm_enable <= 1'b0;
            if (r_state == S_SQR && w_cur_bit) begin
              // Multiply for this bit; idx advances after the multiply.
              r_next_op <= S_MUL;
              r_state   <= S_GAP;
            end else if (r_idx != '0) begin
              r_idx     <= r_idx - 1'b1;
              r_next_op <= S_SQR;
              r_state   <= S_GAP;
            end else begin
              r_state <= S_FIN;
            end
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            // The first enable cycle counts as zero, so this is the
            // TIMEOUT-th cycle spent waiting.
            r_mm_enable <= 1'b0;
            r_abort     <= 1'b1;
            r_state     <= S_FIN;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_GAP: begin
          // One low cycle so ModMul always sees a falling enable edge.
          // Operands are loaded here, while enable is low, and then held.
          r_mm_a      <= r_acc;
          r_mm_b      <= (r_next_op == S_MUL) ? r_base : r_acc;
          r_mm_enable <= 1'b1;
          r_tmo       <= '0;
          r_state     <= r_next_op;
        end

        S_FIN: begin
          r_result <= r_abort ? '0 : r_acc;
          r_err    <= r_abort;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_mm_enable <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign err       = r_err;
  assign mm_a      = r_mm_a;
  assign mm_b      = r_mm_b;
  assign mm_enable = r_mm_enable;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mod_exp_ctrl
//   Directed bench for mod_exp_ctrl with a small behavioural ModMul (p = 37,
//   fixed 3-cycle latency). Expected results, operand sequences and latencies
//   are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mod_exp_ctrl;

  localparam int WIDTH     = 16;
  localparam int EXP_WIDTH = 8;
  localparam int TIMEOUT   = 64;
  localparam int MM_LAT    = 3;
  localparam int P         = 37;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [WIDTH-1:0]     base = '0;
  logic [EXP_WIDTH-1:0] exponent = '0;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic                 err;
  logic [WIDTH-1:0]     mm_a;
  logic [WIDTH-1:0]     mm_b;
  logic                 mm_enable;
  logic [WIDTH-1:0]     mm_r = '0;
  logic                 mm_done = 1'b0;

  // ModMul model controls
  logic hang = 1'b0;       // never assert mm_done
  logic spurious = 1'b0;   // assert mm_done with junk data while enable is low
  int   mm_cnt = 0;

  int total = 0;
  int bad = 0;

  logic [WIDTH-1:0] op_a [8];
  logic [WIDTH-1:0] op_b [8];

  mod_exp_ctrl #(
    .WIDTH    (WIDTH),
    .EXP_WIDTH(EXP_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .exponent (exponent),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .err      (err),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_enable(mm_enable),
    .mm_r     (mm_r),
    .mm_done  (mm_done)
  );

  always #5 clk = ~clk;

  // Behavioural ModMul: mm_done in the MM_LAT-th enable-high cycle.
  always @(negedge clk) begin
    if (reset || !mm_enable) begin
      mm_cnt  = 0;
      mm_done = spurious && !reset;
      mm_r    = spurious ? 16'h00aa : '0;
    end else begin
      mm_cnt = mm_cnt + 1;
      if (!hang && mm_cnt == MM_LAT) begin
        mm_done = 1'b1;
        mm_r    = 16'((32'(mm_a) * 32'(mm_b)) % P);
      end else begin
        mm_done = 1'b0;
        mm_r    = 16'h0055;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to done. restart_at > 0 pulses start
  // (with other operands) in that cycle; it must be ignored.
  task automatic run(input string tag, input logic [WIDTH-1:0] b,
                     input logic [EXP_WIDTH-1:0] e, input logic [WIDTH-1:0] exp_res,
                     input logic exp_err, input int exp_ops, input int exp_en_hi,
                     input int exp_lat, input int restart_at);
    int cyc, ops, en_hi, unstable, busy_bad;
    logic prev_en;
    logic [WIDTH-1:0] pa, pb;
    base = b; exponent = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; ops = 0; en_hi = 0; unstable = 0; busy_bad = 0;
    prev_en = 1'b0; pa = '0; pb = '0;
    while (!done && cyc < 400) begin
      if (mm_enable) begin
        en_hi++;
        if (!prev_en) begin
          if (ops < 8) begin
            op_a[ops] = mm_a;
            op_b[ops] = mm_b;
          end
          ops++;
        end else if (mm_a != pa || mm_b != pb) begin
          unstable++;
        end
      end
      if (!busy) busy_bad++;
      prev_en = mm_enable; pa = mm_a; pb = mm_b;
      if (cyc == restart_at) begin
        start = 1'b1; base = 16'd5; exponent = 8'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " err"}, err, exp_err);
    check({tag, " enable pulses"}, ops, exp_ops);
    check({tag, " enable-high cycles"}, en_hi, exp_en_hi);
    check({tag, " operand stability"}, unstable, 0);
    check({tag, " busy low while running"}, busy_bad, 0);
    check({tag, " busy in done cycle"}, busy, 0);
    @(negedge clk);
    check({tag, " done single pulse"}, done, 0);
    check({tag, " idle after done"}, busy, 0);
  endtask

  initial begin
    int seen, rises;
    logic prev_en;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst err", err, 0);
    check("rst mm_enable", mm_enable, 0);
    check("rst mm_a|mm_b", mm_a | mm_b, 0);
    reset = 1'b0;
    @(negedge clk);

    // 3^5 mod 37: SQR(3) -> 9, SQR(9) -> 7, MUL(7*3) -> 21
    run("3^5", 16'd3, 8'd5, 16'd21, 1'b0, 3, 9, 13, 0);
    check("3^5 op0 a", op_a[0], 3);
    check("3^5 op0 b", op_b[0], 3);
    check("3^5 op1 a", op_a[1], 9);
    check("3^5 op2 a", op_a[2], 7);
    check("3^5 op2 b", op_b[2], 3);

    // 2^10 mod 37: SQR 4, SQR 16, MUL 32, SQR 1024 mod 37 = 25
    run("2^10", 16'd2, 8'd10, 16'd25, 1'b0, 4, 12, 17, 0);
    check("2^10 op2 a", op_a[2], 16);
    check("2^10 op2 b", op_b[2], 2);
    check("2^10 op3 a", op_a[3], 32);

    // Trivial exponents: no ModMul traffic, done two cycles after start
    run("x^0", 16'd7, 8'd0, 16'd1, 1'b0, 0, 0, 2, 0);
    run("12^1", 16'd12, 8'd1, 16'd12, 1'b0, 0, 0, 2, 0);

    // ModMul never answers: 64 enable-high cycles, then abort
    hang = 1'b1;
    run("timeout", 16'd3, 8'd5, 16'd0, 1'b1, 1, TIMEOUT, TIMEOUT + 2, 0);
    hang = 1'b0;
    run("after timeout", 16'd3, 8'd5, 16'd21, 1'b0, 3, 9, 13, 0);

    // start mid-operation (cycle 5) and in FIN (cycle 12) is ignored
    run("restart mid-op", 16'd3, 8'd5, 16'd21, 1'b0, 3, 9, 13, 5);
    run("restart in FIN", 16'd3, 8'd5, 16'd21, 1'b0, 3, 9, 13, 12);

    // Junk mm_done while enable is low must be ignored
    spurious = 1'b1;
    run("spurious done", 16'd2, 8'd10, 16'd25, 1'b0, 4, 12, 17, 0);
    spurious = 1'b0;
    @(negedge clk);

    // Reset during the second SQR
    base = 16'd3; exponent = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rises = 0; prev_en = 1'b0; seen = 0;
    while (rises < 2 && seen < 100) begin
      if (mm_enable && !prev_en) rises++;
      prev_en = mm_enable;
      if (rises < 2) begin
        @(negedge clk);
        seen++;
      end
    end
    check("reach second SQR", rises, 2);
    reset = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst result", result, 0);
    check("midrst err", err, 0);
    check("midrst mm_enable", mm_enable, 0);
    check("midrst mm_a|mm_b", mm_a | mm_b, 0);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || mm_enable || busy) seen++;
    end
    check("midrst quiet", seen, 0);

    run("after reset", 16'd2, 8'd10, 16'd25, 1'b0, 4, 12, 17, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
